mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_WIDTH, default 10, giving the word-address width of the memory port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width of all ports.
REQ-003 The block SHALL have parameter TRANSFER_WIDTH, default 4, giving the byte-enable width.
REQ-004 The block SHALL use one clock, clk, and an asynchronous, active-high reset, rst.
REQ-005 The block SHALL have the following ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- prog_req_i  input  1  instruction-fetch request
- prog_addr_i  input  MEM_ADDR_WIDTH  fetch address
- prog_gnt_o  output  1  fetch accepted this cycle
- prog_rvalid_o  output  1  fetch data valid
- prog_rdata_o  output  DATA_WIDTH  fetch data
- data_req_i  input  1  load/store request
- data_we_i  input  1  1 = store, 0 = load
- data_addr_i  input  MEM_ADDR_WIDTH  load/store address
- data_wdata_i  input  DATA_WIDTH  store data
- data_be_i  input  TRANSFER_WIDTH  store byte enables
- data_gnt_o  output  1  load/store accepted this cycle
- data_rvalid_o  output  1  load data valid
- data_rdata_o  output  DATA_WIDTH  load data
- mem_en_o  output  1  memory access strobe
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  MEM_ADDR_WIDTH  memory address
- mem_wdata_o  output  DATA_WIDTH  memory write data
- mem_be_o  output  TRANSFER_WIDTH  memory byte enables
- mem_rdata_i  input  DATA_WIDTH  memory read data, valid one cycle after a read strobe
- conflict_cnt_o  output  16  saturating count of denied-request cycles

Function
REQ-006 A request SHALL be accepted in the cycle its req is high and its gnt is high. Grant is combinational from the req inputs and the registered arbitration state.
REQ-007 Requesters SHALL hold req, addr, we, wdata and be stable until gnt. The block SHALL not store pending requests.
REQ-008 At most one of prog_gnt_o and data_gnt_o SHALL be high in any cycle.
REQ-009 A lone request SHALL be granted in the same cycle.
REQ-010 With no request, the block SHALL drive mem_en_o=0, mem_we_o=0, and mem_addr_o, mem_wdata_o and mem_be_o all zero.
REQ-011 On a grant, the block SHALL set mem_en_o=1 and drive the mem_* outputs from the granted requester:
- prog grant: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
REQ-012 The block SHALL keep a registered read-owner state with values NONE, PROG and DATA:
- prog grant -> PROG.
- data load grant -> DATA.
- data store grant or no grant -> NONE.
REQ-013 prog_rvalid_o SHALL equal (owner==PROG) and data_rvalid_o SHALL equal (owner==DATA), so read latency is exactly 1 cycle after the grant.
REQ-014 prog_rdata_o and data_rdata_o SHALL pass mem_rdata_i through unchanged. Each is meaningful only while its rvalid is high.
REQ-015 Stores SHALL produce no rvalid. A store completes on its grant cycle.
REQ-016 Back-to-back grants on consecutive cycles SHALL be supported with no bubble. An rvalid and a new grant may coincide.
REQ-017 conflict_cnt_o SHALL increment by 1 each cycle both req inputs are high, and SHALL saturate at 0xFFFF (no wrap).

Reset
REQ-018 While rst is high, the block SHALL clear owner to NONE, clear conflict_cnt_o to 0, and set the round-robin pointer to "last=DATA".
REQ-019 While rst is high, both gnt outputs, both rvalid outputs and mem_en_o SHALL be 0 regardless of the req inputs.
REQ-020 A read granted in the cycle before reset asserts SHALL be dropped: no rvalid after reset.

Configuration
REQ-021 With macro MEM_ARBITER_RR_EN defined, a conflict (both req high) SHALL grant the requester not granted most recently:
- The pointer updates on every grant.
- The first conflict after reset grants prog.
REQ-022 With MEM_ARBITER_RR_EN undefined, a conflict SHALL always grant data (fixed priority), and no pointer register SHALL exist.

Verification
REQ-023 Lone fetch: prog_req_i=1, prog_addr_i=0x004, mem_rdata_i=0x00500093 next cycle -> prog_gnt_o=1 and mem_addr_o=0x004 in the same cycle; prog_rvalid_o=1 with prog_rdata_o=0x00500093 one cycle later.
REQ-024 Store: data_req_i=1, data_we_i=1, data_addr_i=0x100, data_wdata_i=0xDEADBEEF, data_be_i=0x3 -> one cycle of mem_en_o=1, mem_we_o=1, mem_be_o=0x3; data_rvalid_o stays 0.
REQ-025 Conflict with MEM_ARBITER_RR_EN: both req held for 4 cycles -> grants prog, data, prog, data; conflict_cnt_o=4.
REQ-026 Conflict without the macro: both req held for 3 cycles -> data_gnt_o=1 on all 3 cycles; prog_gnt_o=0 on all 3.
REQ-027 Reset mid-read: prog grant at cycle N, rst=1 at cycle N+1 -> prog_rvalid_o=0; owner=NONE; conflict_cnt_o=0.
REQ-028 Saturation: both req held for 65540 cycles -> conflict_cnt_o=0xFFFF and holds.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/load-store) single-port memory arbiter; optional round-robin via MEM_ARBITER_RR_EN
module mem_arbiter #(
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int TRANSFER_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      prog_req_i,
   input  logic [MEM_ADDR_WIDTH-1:0] prog_addr_i,
   output logic                      prog_gnt_o,
   output logic                      prog_rvalid_o,
   output logic [DATA_WIDTH-1:0]     prog_rdata_o,
   input  logic                      data_req_i,
   input  logic                      data_we_i,
   input  logic [MEM_ADDR_WIDTH-1:0] data_addr_i,
   input  logic [DATA_WIDTH-1:0]     data_wdata_i,
   input  logic [TRANSFER_WIDTH-1:0] data_be_i,
   output logic                      data_gnt_o,
   output logic                      data_rvalid_o,
   output logic [DATA_WIDTH-1:0]     data_rdata_o,
   output logic                      mem_en_o,
   output logic                      mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   output logic [TRANSFER_WIDTH-1:0] mem_be_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
   output logic [15:0]               conflict_cnt_o
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_PROG = 2'd1,
      OWN_DATA = 2'd2
   } owner_t;

   owner_t      owner_q;
   owner_t      owner_d;
   logic        prog_gnt;
   logic        data_gnt;
   logic        conflict;
   logic [15:0] conflict_cnt_q;

   assign conflict = prog_req_i & data_req_i;

`ifdef MEM_ARBITER_RR_EN
   // 1 when data was the most recent grant; reset value makes the first conflict go to prog
   logic last_data_q;

   // Remember which requester was granted last, on every grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_data_q <= 1'b1;
      end else if (prog_gnt) begin
         last_data_q <= 1'b0;
      end else if (data_gnt) begin
         last_data_q <= 1'b1;
      end
   end

   // Round-robin grant: on conflict favour whoever was not granted last
   always_comb begin
      prog_gnt = 1'b0;
      data_gnt = 1'b0;
      if (!rst) begin
         if (conflict) begin
            prog_gnt = last_data_q;
            data_gnt = ~last_data_q;
         end else begin
            prog_gnt = prog_req_i;
            data_gnt = data_req_i;
         end
      end
   end
`else
   // Fixed-priority grant: data wins every conflict
   always_comb begin
      prog_gnt = 1'b0;
      data_gnt = 1'b0;
      if (!rst) begin
         data_gnt = data_req_i;
         prog_gnt = prog_req_i & ~data_req_i;
      end
   end
`endif

   // Read-owner register: remembers whose read data arrives next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Next read owner and memory port mux from the granted requester
   always_comb begin
      owner_d     = OWN_NONE;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (prog_gnt) begin
         owner_d    = OWN_PROG;
         mem_en_o   = 1'b1;
         mem_addr_o = prog_addr_i;
         mem_be_o   = '1;
      end else if (data_gnt) begin
         owner_d     = data_we_i ? OWN_NONE : OWN_DATA;
         mem_en_o    = 1'b1;
         mem_we_o    = data_we_i;
         mem_addr_o  = data_addr_i;
         mem_wdata_o = data_wdata_i;
         mem_be_o    = data_be_i;
      end
   end

   // Count cycles where both requesters collide, sticking at the top value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt_q <= 16'd0;
      end else if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
   end

   assign prog_gnt_o     = prog_gnt;
   assign data_gnt_o     = data_gnt;
   assign prog_rvalid_o  = (owner_q == OWN_PROG);
   assign data_rvalid_o  = (owner_q == OWN_DATA);
   assign prog_rdata_o   = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (vector table, directed sequences, random vs reference model)
module tb_mem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          prog_req_i;
   logic [AW-1:0] prog_addr_i;
   logic          prog_gnt_o;
   logic          prog_rvalid_o;
   logic [DW-1:0] prog_rdata_o;
   logic          data_req_i;
   logic          data_we_i;
   logic [AW-1:0] data_addr_i;
   logic [DW-1:0] data_wdata_i;
   logic [BW-1:0] data_be_i;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic [DW-1:0] data_rdata_o;
   logic          mem_en_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [BW-1:0] mem_be_o;
   logic [DW-1:0] mem_rdata_i;
   logic [15:0]   conflict_cnt_o;

   mem_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRANSFER_WIDTH(BW)) dut (
      .clk(clk), .rst(rst),
      .prog_req_i(prog_req_i), .prog_addr_i(prog_addr_i), .prog_gnt_o(prog_gnt_o),
      .prog_rvalid_o(prog_rvalid_o), .prog_rdata_o(prog_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
      .conflict_cnt_o(conflict_cnt_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the returning read, who was granted last, conflict tally, memory image
   int            own_m;        // 0 none, 1 prog, 2 data
   bit            last_data_m;
   int            cnt_m;
   logic [DW-1:0] mem_m [1024];
   logic [DW-1:0] rd_pending;

   typedef struct {
      bit            pr;
      bit            dr;
      bit            we;
      logic [AW-1:0] pa;
      logic [AW-1:0] da;
      logic [DW-1:0] wd;
      logic [BW-1:0] be;
      bit            epg;
      bit            edg;
      bit            een;
      bit            ewe;
      logic [AW-1:0] eaddr;
      logic [BW-1:0] ebe;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit pr, input logic [AW-1:0] pa, input bit dr, input bit we,
                        input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic [BW-1:0] be);
      prog_req_i   = pr;
      prog_addr_i  = pa;
      data_req_i   = dr;
      data_we_i    = we;
      data_addr_i  = da;
      data_wdata_i = wd;
      data_be_i    = be;
   endtask

   // Arbitration rule straight from the requirement text
   task automatic exp_grant(output bit pg, output bit dg);
      pg = 1'b0;
      dg = 1'b0;
      if (prog_req_i && data_req_i) begin
`ifdef MEM_ARBITER_RR_EN
         pg = last_data_m;
         dg = !last_data_m;
`else
         dg = 1'b1;
`endif
      end else begin
         pg = prog_req_i;
         dg = data_req_i;
      end
   endtask

   // One clocked cycle out of reset: compare every output to the model, then advance the model
   task automatic cycle(output bit pg, output bit dg);
      logic [DW-1:0] rd_next;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      logic [BW-1:0] eb;
      rd_next = $urandom;
      @(negedge clk);
      exp_grant(pg, dg);
      ea = pg ? prog_addr_i : (dg ? data_addr_i : '0);
      ew = (dg && !pg) ? data_wdata_i : '0;
      eb = pg ? {BW{1'b1}} : (dg ? data_be_i : '0);
      chk("prog_gnt", prog_gnt_o, pg);
      chk("data_gnt", data_gnt_o, dg);
      chk("mem_en", mem_en_o, pg | dg);
      chk("mem_we", mem_we_o, dg & data_we_i);
      chk("mem_addr", mem_addr_o, ea);
      chk("mem_wdata", mem_wdata_o, ew);
      chk("mem_be", mem_be_o, eb);
      chk("prog_rvalid", prog_rvalid_o, own_m == 1);
      chk("data_rvalid", data_rvalid_o, own_m == 2);
      if (own_m == 1) chk("prog_rdata", prog_rdata_o, rd_pending);
      if (own_m == 2) chk("data_rdata", data_rdata_o, rd_pending);
      chk("conflict_cnt", conflict_cnt_o, cnt_m);
      @(posedge clk);
      if (prog_req_i && data_req_i && cnt_m < 65535) cnt_m++;
      own_m = 0;
      if (pg) begin
         own_m       = 1;
         last_data_m = 1'b0;
         rd_next     = mem_m[prog_addr_i];
      end else if (dg) begin
         last_data_m = 1'b1;
         if (data_we_i) begin
            for (int b = 0; b < BW; b++)
               if (data_be_i[b]) mem_m[data_addr_i][8*b +: 8] = data_wdata_i[8*b +: 8];
         end else begin
            own_m   = 2;
            rd_next = mem_m[data_addr_i];
         end
      end
      #1;
      rd_pending  = rd_next;
      mem_rdata_i = rd_next;
   endtask

   // Assert reset with requests active, check outputs are quiet, then release
   task automatic do_reset();
      rst = 1'b1;
      drive(1'b1, 10'h3, 1'b1, 1'b0, 10'h7, 32'h0, 4'hF);
      #3;
      chk("rst_prog_gnt", prog_gnt_o, 0);
      chk("rst_data_gnt", data_gnt_o, 0);
      chk("rst_prog_rvalid", prog_rvalid_o, 0);
      chk("rst_data_rvalid", data_rvalid_o, 0);
      chk("rst_mem_en", mem_en_o, 0);
      chk("rst_conflict_cnt", conflict_cnt_o, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      own_m       = 0;
      last_data_m = 1'b1;
      cnt_m       = 0;
   endtask

   initial begin
      bit pg, dg;
      bit p_hold, d_hold;
      bit exp_seq [4];

      rst         = 1'b1;
      mem_rdata_i = '0;
      rd_pending  = '0;
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 1024; i++) mem_m[i] = i * 32'h01010101;
      mem_m[4] = 32'h00500093;
      @(posedge clk);
      #1;
      do_reset();

      // Single-cycle vectors valid in both arbitration modes (no conflicts)
      tbl[0] = '{0, 0, 0, 10'h000, 10'h000, 32'h0,        4'h0, 0, 0, 0, 0, 10'h000, 4'h0};
      tbl[1] = '{1, 0, 0, 10'h004, 10'h055, 32'h1234,     4'h1, 1, 0, 1, 0, 10'h004, 4'hF};
      tbl[2] = '{0, 1, 0, 10'h000, 10'h010, 32'h0,        4'h5, 0, 1, 1, 0, 10'h010, 4'h5};
      tbl[3] = '{0, 1, 1, 10'h000, 10'h100, 32'hDEADBEEF, 4'h3, 0, 1, 1, 1, 10'h100, 4'h3};
      tbl[4] = '{1, 0, 0, 10'h3FF, 10'h000, 32'h0,        4'h0, 1, 0, 1, 0, 10'h3FF, 4'hF};
      tbl[5] = '{0, 0, 0, 10'h000, 10'h000, 32'h0,        4'h0, 0, 0, 0, 0, 10'h000, 4'h0};
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].pr, tbl[i].pa, tbl[i].dr, tbl[i].we, tbl[i].da, tbl[i].wd, tbl[i].be);
         #3;
         chk($sformatf("tbl%0d_prog_gnt", i), prog_gnt_o, tbl[i].epg);
         chk($sformatf("tbl%0d_data_gnt", i), data_gnt_o, tbl[i].edg);
         chk($sformatf("tbl%0d_mem_en", i), mem_en_o, tbl[i].een);
         chk($sformatf("tbl%0d_mem_we", i), mem_we_o, tbl[i].ewe);
         chk($sformatf("tbl%0d_mem_addr", i), mem_addr_o, tbl[i].eaddr);
         chk($sformatf("tbl%0d_mem_be", i), mem_be_o, tbl[i].ebe);
         cycle(pg, dg);
      end

      // Lone fetch with one-cycle read latency
      drive(1'b1, 10'h004, 1'b0, 1'b0, '0, '0, '0);
      #3;
      chk("fetch_gnt", prog_gnt_o, 1);
      chk("fetch_addr", mem_addr_o, 32'h004);
      cycle(pg, dg);
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      #3;
      chk("fetch_rvalid", prog_rvalid_o, 1);
      chk("fetch_rdata", prog_rdata_o, 32'h00500093);
      cycle(pg, dg);

      // Store: one strobe, no read data
      drive(1'b0, '0, 1'b1, 1'b1, 10'h100, 32'hDEADBEEF, 4'h3);
      #3;
      chk("store_en", mem_en_o, 1);
      chk("store_we", mem_we_o, 1);
      chk("store_be", mem_be_o, 32'h3);
      chk("store_wdata", mem_wdata_o, 32'hDEADBEEF);
      cycle(pg, dg);
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      #3;
      chk("store_no_rvalid", data_rvalid_o, 0);
      chk("store_en_off", mem_en_o, 0);
      cycle(pg, dg);

      // Sustained conflict straight after reset
      do_reset();
`ifdef MEM_ARBITER_RR_EN
      exp_seq = '{1, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
`else
      exp_seq = '{0, 0, 0, 0};
      for (int i = 0; i < 3; i++) begin
`endif
         drive(1'b1, 10'h020, 1'b1, 1'b0, 10'h030, '0, 4'hF);
         #3;
         chk($sformatf("conflict%0d_prog_gnt", i), prog_gnt_o, exp_seq[i]);
         chk($sformatf("conflict%0d_data_gnt", i), data_gnt_o, !exp_seq[i]);
         cycle(pg, dg);
      end
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      #3;
`ifdef MEM_ARBITER_RR_EN
      chk("conflict_total", conflict_cnt_o, 4);
`else
      chk("conflict_total", conflict_cnt_o, 3);
`endif
      cycle(pg, dg);

      // Reset arriving right after a fetch grant drops the returning read
      drive(1'b1, 10'h008, 1'b1, 1'b0, 10'h00C, '0, 4'hF);
      cycle(pg, dg);
      drive(1'b1, 10'h008, 1'b0, 1'b0, '0, '0, '0);
      cycle(pg, dg);
      rst = 1'b1;
      #3;
      chk("midread_prog_rvalid", prog_rvalid_o, 0);
      chk("midread_data_rvalid", data_rvalid_o, 0);
      chk("midread_conflict_cnt", conflict_cnt_o, 0);
      do_reset();

      // Randomized traffic; requesters hold their request until granted
      p_hold = 1'b0;
      d_hold = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (!p_hold) begin
            prog_req_i  = ($urandom_range(0, 99) < 60);
            prog_addr_i = AW'($urandom_range(0, 15));
         end
         if (!d_hold) begin
            data_req_i   = ($urandom_range(0, 99) < 60);
            data_we_i    = $urandom_range(0, 1);
            data_addr_i  = AW'($urandom_range(0, 15));
            data_wdata_i = $urandom;
            data_be_i    = BW'($urandom_range(0, 15));
         end
         cycle(pg, dg);
         p_hold = prog_req_i && !pg;
         d_hold = data_req_i && !dg;
      end

      // Saturation of the conflict counter
      do_reset();
      drive(1'b1, 10'h001, 1'b1, 1'b0, 10'h002, '0, 4'hF);
      repeat (65540) @(posedge clk);
      #3;
      chk("sat_cnt", conflict_cnt_o, 32'hFFFF);
      @(posedge clk);
      #3;
      chk("sat_hold", conflict_cnt_o, 32'hFFFF);
      @(posedge clk);
      #1;
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
